logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit with eight operations, a valid/ready handshake and an optional sticky-OR accumulator.
- Successor to the fixed-width combinational OR gate; a single block now serves the ALU logic ops (AND/OR/XOR and their variants).
- The accumulator supports mask/flag gathering across multiple operations.
- Sits between operand fetch and writeback as a one-deep pipeline stage.

Parameters:
- WIDTH, 64, operand/result width in bits (≥1).
- ACC_EN, 1, 1 = accumulator implemented; 0 = in_acc/acc_clr ignored, acc_q tied to 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select.
- in_acc  input  1  accumulate this beat into acc.
- acc_clr  input  1  synchronous accumulator clear.
- out_valid  output  1  result register holds a valid beat.
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  registered result.
- out_zero  output  1  registered flag: out_y == 0.
- acc_q  output  WIDTH  current accumulator value.

Behaviour:
- Reset (rst_n low, asynchronous, any time incl. mid-transfer): out_valid=0, out_y=0, out_zero=1, acc_q=0; in_ready=1 once out_valid=0. Any pending beat is lost.
- in_op decode, f(a,b):
  - 000 AND a&b
  - 001 OR a|b
  - 010 XOR a^b
  - 011 NOR ~(a|b)
  - 100 ANDN a&~b
  - 101 ORN a|~b
  - 110 XNOR ~(a^b)
  - 111 PASS a
- All ops are bitwise, WIDTH bits, no carries; results are never truncated or extended.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready.
  - Latency: 1 cycle; accepted beat appears on out_y/out_valid next edge.
  - Throughput: 1 beat/cycle with out_ready held high.
- Output register:
  - On accept: out_valid<=1, out_y<=r, out_zero<=(r==0).
  - Else if out_ready: out_valid<=0; out_y/out_zero hold their last value.
  - While out_valid & ~out_ready: out_y and out_zero are stable, and in_ready=0.
  - Simultaneous drain and accept: out_valid stays 1 and the new beat replaces the old one; no bubble.
- Result r and accumulator (ACC_EN=1):
  - Let base = acc_clr ? 0 : acc_q.
  - Accept with in_acc=1: r = f(a,b) | base; acc_q <= r.
  - Accept with in_acc=0: r = f(a,b); acc_q <= base.
  - No accept: acc_q <= base (acc_clr alone clears next edge).
  - acc_clr together with an accumulate beat therefore clears first, then accumulates: acc_q = f(a,b).
  - acc_q only changes on accept or acc_clr; it is independent of out_ready beyond that.
- ACC_EN=0: r = f(a,b) always; acc_q=0 constant; in_acc and acc_clr are don't-care.
- in_valid low: inputs are don't-care; no state change except a drain or acc_clr.
- Unknown/undriven in_op is not a legal case; all 8 codes are defined.

Test Plan:
- Reset/idle: hold rst_n=0 then release -> out_valid=0, out_y=0, out_zero=1, acc_q=0, in_ready=1. Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge.
- Op sweep (WIDTH=64, out_ready=1): a=0xF0F0_0000_FFFF_1234, b=0xFF00_FFFF_0000_1234, all 8 ops back-to-back -> one result per cycle, 1-cycle latency. Expected results:
  - AND = 0xF000_0000_0000_1234
  - OR = 0xFFF0_FFFF_FFFF_1234
  - XOR = 0x0FF0_FFFF_FFFF_0000
  - NOR = 0x000F_0000_0000_EDCB
  - ANDN = 0x00F0_0000_FFFF_0000
  - ORN = 0xF0FF_0000_FFFF_FFFF
  - XNOR = 0xF00F_0000_0000_FFFF
  - PASS = a
- Zero flag: XOR with a=b=0xDEAD_BEEF_0000_0001 -> out_y=0, out_zero=1; next beat OR a=1, b=0 -> out_zero=0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_y stable for all 3 cycles. out_ready=1 -> old beat drained and new beat loaded on the same edge; no beat lost or duplicated (scoreboard count matches).
- Accumulate: acc_clr pulse, then OR beats with in_acc=1: (0x1,0x0), (0x4,0x0), (0x0,0x100) -> acc_q = 0x1, 0x5, 0x105; out_y matches each step.
  - Then in_acc=0 AND beat -> acc_q stays 0x105.
  - Then acc_clr with an accumulate beat PASS a=0x8 -> acc_q=0x8, out_y=0x8.
- Parameter corners: WIDTH=1 and WIDTH=32 with ACC_EN=0 -> all ops correct, acc_q=0 constant, in_acc toggling has no effect on out_y.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: eight ops, valid/ready output stage,
// optional sticky-OR accumulator for gathering masks across beats.
module logic_unit_pipe #(
   parameter int unsigned WIDTH  = 64,
   parameter bit          ACC_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [WIDTH-1:0] acc_q
);

   logic             accept;
   logic [WIDTH-1:0] f_res;
   logic [WIDTH-1:0] r;

   logic             valid_q, valid_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] y_q, y_d;

   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   always_comb begin
      f_res = in_a;
      unique case (in_op)
         3'b000: f_res = in_a & in_b;
         3'b001: f_res = in_a | in_b;
         3'b010: f_res = in_a ^ in_b;
         3'b011: f_res = ~(in_a | in_b);
         3'b100: f_res = in_a & ~in_b;
         3'b101: f_res = in_a | ~in_b;
         3'b110: f_res = ~(in_a ^ in_b);
         3'b111: f_res = in_a;
      endcase
   end

   generate
      if (ACC_EN) begin : g_acc
         logic [WIDTH-1:0] base;
         logic [WIDTH-1:0] acc_d;
         logic [WIDTH-1:0] acc_val_q;

         // Clear wins first, so clear+accumulate leaves just f(a,b).
         always_comb begin
            base  = acc_clr ? '0 : acc_val_q;
            r     = f_res;
            acc_d = base;
            if (accept && in_acc) begin
               r     = f_res | base;
               acc_d = f_res | base;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_val_q <= '0;
            end else begin
               acc_val_q <= acc_d;
            end
         end

         assign acc_q = acc_val_q;
      end else begin : g_noacc
         logic unused_acc;
         assign unused_acc = in_acc ^ acc_clr;
         assign r          = f_res;
         assign acc_q      = '0;
      end
   endgenerate

   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      zero_d  = zero_q;
      if (accept) begin
         valid_d = 1'b1;
         y_d     = r;
         zero_d  = (r == '0);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         y_q     <= '0;
         zero_q  <= 1'b1;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid = valid_q;
   assign out_y     = y_q;
   assign out_zero  = zero_q;

endmodule
